ecc_apb_sequencer: RTL and testbench
====================================

// Module: ecc_apb_sequencer
// PURPOSE
//  APB master that sequences ECC_ENC_DEC. Takes one job (op, codeword width, data, noise) on a valid/ready
//  command port, programs the ECC register file over APB and starts the operation. It then waits for
//  operation_done and returns data_out/num_of_errors on a valid/ready result port.
//  Sits between the system job source and the ECC core; one job in flight at a time.
// PARAMETERS
//  DATA_WIDTH       32    width of data/noise words and ECC data_out
//  AMBA_ADDR_WIDTH  20    PADDR width
//  AMBA_WORD        32    PWDATA width
//  TIMEOUT_CYCLES   1024  max WAIT_DONE cycles before abort (>=2)
// PORTS
//  clk            in   1                clock
//  rst            in   1                asynchronous reset, active-low
//  cmd_valid      in   1                job offered
//  cmd_ready      out  1                job accepted when valid&ready
//  cmd_op         in   2                0 encode, 1 decode, 2 full, 3 illegal
//  cmd_width      in   2                0=8b, 1=16b, 2=32b codeword, 3 illegal
//  cmd_data       in   DATA_WIDTH       DATA_IN value
//  cmd_noise      in   DATA_WIDTH       NOISE value
//  PADDR          out  AMBA_ADDR_WIDTH  APB address to ECC
//  PWDATA         out  AMBA_WORD        APB write data
//  PSEL/PENABLE/PWRITE out 1 each       APB control
//  operation_done in   1                ECC completion pulse
//  data_out       in   DATA_WIDTH       ECC result
//  num_of_errors  in   2                ECC error count
//  res_valid      out  1                result held until res_ready
//  res_ready      in   1                result consumed
//  res_data       out  DATA_WIDTH       captured data_out
//  res_errors     out  2                captured num_of_errors
//  res_status     out  2                00 ok, 01 timeout, 10 illegal job
//  busy           out  1                high in any state but IDLE
// BEHAVIOUR
//  Reset (rst=0, async): FSM->IDLE; all outputs 0; shadow regs invalid; timeout counter 0.
//  FSM: IDLE -> SETUP -> ACCESS -> (SETUP for next reg | WAIT_DONE) -> RESP -> IDLE.
//  IDLE: cmd_ready=1; on accept latch cmd_*; if op==3 or width==3 -> RESP (status 10, data/errors 0,
//   no APB traffic, res_valid at accept+1); else -> SETUP.
//  Write order: DATA_IN 0x04, CODEWORD_WIDTH 0x08, NOISE 0x0C, CTRL 0x00 (CTRL last = start).
//  APB write: SETUP PSEL=1 PENABLE=0 PWRITE=1 PADDR/PWDATA valid; ACCESS PENABLE=1; no wait states.
//   PADDR/PWDATA stable across both phases; PSEL/PENABLE/PWRITE=0 outside transfers; PWDATA zero-extended.
//  Latency: accept at edge T -> writes in cycles T+1..T+8 -> WAIT_DONE from T+9.
//  WAIT_DONE: counter increments each cycle; operation_done=1 sampled -> capture data_out/num_of_errors,
//   status 00, res_valid next cycle. Counter reaching TIMEOUT_CYCLES with no done -> status 01,
//   data/errors 0. done and timeout in the same cycle -> done wins (status 00).
//  operation_done outside WAIT_DONE: ignored.
//  RESP: res_* held stable while res_valid=1 and res_ready=0; on res_ready -> IDLE. cmd_ready=1
//   earliest the cycle after the handshake (no same-cycle accept).
//  Reset mid-transfer: APB signals drop to 0 immediately; job discarded, no result issued.
// CONFIGURATION
//  ECC_SEQ_SKIP_UNCHANGED_EN defined: shadow regs hold last written CODEWORD_WIDTH and NOISE;
//   a write is skipped when the value matches and the shadow is valid (2 cycles saved each).
//   DATA_IN and CTRL are always written. Shadows are invalidated by reset and by any timeout.
//  Undefined: all four registers written every job; no shadow logic.
// TESTING
//  1 encode, width 2, data 0x0000_00A5, noise 0 -> 4 APB writes, CTRL PWDATA=0 last,
//    WAIT_DONE at T+9, res_status 00, res_data = data_out at done.
//  2 cmd_op=3 -> no PSEL activity, res_valid at T+1, res_status 10, res_data 0.
//  3 TIMEOUT_CYCLES=16, operation_done held 0 -> res_valid 17 cycles after WAIT_DONE entry, status 01.
//  4 res_ready held 0 for 10 cycles -> res_* stable, cmd_ready 0, busy 1; release -> IDLE next cycle.
//  5 rst low during ACCESS of NOISE write -> PSEL/PENABLE 0 at once; after release cmd_ready=1,
//    no res_valid for the aborted job.
//  6 [SKIP_EN] two jobs with identical width/noise -> 2nd job issues 2 writes (DATA_IN, CTRL), WAIT_DONE at T+5.

Source files
------------

// File: rtl/ecc_apb_sequencer.sv
// ecc_apb_sequencer: APB master that programs ECC_ENC_DEC for one job and returns its result.
// Optional macro ECC_SEQ_SKIP_UNCHANGED_EN skips CODEWORD_WIDTH/NOISE writes matching the shadows.
module ecc_apb_sequencer #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [1:0]                 cmd_width,
    input  logic [DATA_WIDTH-1:0]      cmd_data,
    input  logic [DATA_WIDTH-1:0]      cmd_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_WIDTH-1:0]      res_data,
    output logic [1:0]                 res_errors,
    output logic [1:0]                 res_status,
    output logic                       busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 idx_q, idx_d, nxt;
    logic [1:0]                 op_q, op_d;
    logic [1:0]                 width_q, width_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic [DATA_WIDTH-1:0]      noise_q, noise_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       psel_q, psel_d;
    logic                       penable_q, penable_d;
    logic                       pwrite_q, pwrite_d;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
    logic                       cmd_ready_q, cmd_ready_d;
    logic                       busy_q, busy_d;
    logic                       res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0]      res_data_q, res_data_d;
    logic [1:0]                 res_errors_q, res_errors_d;
    logic [1:0]                 res_status_q, res_status_d;
`ifdef ECC_SEQ_SKIP_UNCHANGED_EN
    logic                       sh_w_vld_q, sh_w_vld_d;
    logic                       sh_n_vld_q, sh_n_vld_d;
    logic [1:0]                 sh_w_q, sh_w_d;
    logic [DATA_WIDTH-1:0]      sh_n_q, sh_n_d;
`endif

    function automatic logic [AMBA_ADDR_WIDTH-1:0] reg_addr(input logic [1:0] idx);
        unique case (idx)
            2'd0:    reg_addr = AMBA_ADDR_WIDTH'(8'h04);
            2'd1:    reg_addr = AMBA_ADDR_WIDTH'(8'h08);
            2'd2:    reg_addr = AMBA_ADDR_WIDTH'(8'h0C);
            default: reg_addr = AMBA_ADDR_WIDTH'(8'h00);
        endcase
    endfunction

    function automatic logic [AMBA_WORD-1:0] reg_wdata(
        input logic [1:0]            idx,
        input logic [1:0]            op,
        input logic [1:0]            w,
        input logic [DATA_WIDTH-1:0] d,
        input logic [DATA_WIDTH-1:0] n
    );
        unique case (idx)
            2'd0:    reg_wdata = AMBA_WORD'(d);
            2'd1:    reg_wdata = AMBA_WORD'(w);
            2'd2:    reg_wdata = AMBA_WORD'(n);
            default: reg_wdata = AMBA_WORD'(op);
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        op_d         = op_q;
        width_d      = width_q;
        data_d       = data_q;
        noise_d      = noise_q;
        cnt_d        = cnt_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_errors_d = res_errors_q;
        res_status_d = res_status_q;
        nxt          = idx_q + 2'd1;
`ifdef ECC_SEQ_SKIP_UNCHANGED_EN
        sh_w_vld_d   = sh_w_vld_q;
        sh_n_vld_d   = sh_n_vld_q;
        sh_w_d       = sh_w_q;
        sh_n_d       = sh_n_q;
        if (nxt == 2'd1 && sh_w_vld_q && sh_w_q == width_q) nxt = 2'd2;
        if (nxt == 2'd2 && sh_n_vld_q && sh_n_q == noise_q) nxt = 2'd3;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = cmd_op;
                    width_d = cmd_width;
                    data_d  = cmd_data;
                    noise_d = cmd_noise;
                    if (cmd_op == 2'd3 || cmd_width == 2'd3) begin
                        state_d      = S_RESP;
                        res_valid_d  = 1'b1;
                        res_status_d = 2'b10;
                        res_data_d   = '0;
                        res_errors_d = '0;
                    end else begin
                        state_d  = S_SETUP;
                        idx_d    = 2'd0;
                        psel_d   = 1'b1;
                        pwrite_d = 1'b1;
                        paddr_d  = reg_addr(2'd0);
                        pwdata_d = reg_wdata(2'd0, cmd_op, cmd_width, cmd_data, cmd_noise);
                    end
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end
            S_ACCESS: begin
`ifdef ECC_SEQ_SKIP_UNCHANGED_EN
                if (idx_q == 2'd1) begin
                    sh_w_d     = width_q;
                    sh_w_vld_d = 1'b1;
                end
                if (idx_q == 2'd2) begin
                    sh_n_d     = noise_q;
                    sh_n_vld_d = 1'b1;
                end
`endif
                penable_d = 1'b0;
                if (idx_q == 2'd3) begin
                    state_d  = S_WAIT;
                    psel_d   = 1'b0;
                    pwrite_d = 1'b0;
                    paddr_d  = '0;
                    pwdata_d = '0;
                    cnt_d    = '0;
                end else begin
                    state_d  = S_SETUP;
                    idx_d    = nxt;
                    paddr_d  = reg_addr(nxt);
                    pwdata_d = reg_wdata(nxt, op_q, width_q, data_q, noise_q);
                end
            end
            S_WAIT: begin
                // done takes priority over a timeout landing on the same cycle
                if (operation_done) begin
                    state_d      = S_RESP;
                    res_valid_d  = 1'b1;
                    res_status_d = 2'b00;
                    res_data_d   = data_out;
                    res_errors_d = num_of_errors;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
                    state_d      = S_RESP;
                    res_valid_d  = 1'b1;
                    res_status_d = 2'b01;
                    res_data_d   = '0;
                    res_errors_d = '0;
`ifdef ECC_SEQ_SKIP_UNCHANGED_EN
                    sh_w_vld_d   = 1'b0;
                    sh_n_vld_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (res_ready) begin
                    state_d     = S_IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            op_q         <= '0;
            width_q      <= '0;
            data_q       <= '0;
            noise_q      <= '0;
            cnt_q        <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_errors_q <= '0;
            res_status_q <= '0;
`ifdef ECC_SEQ_SKIP_UNCHANGED_EN
            sh_w_vld_q   <= 1'b0;
            sh_n_vld_q   <= 1'b0;
            sh_w_q       <= '0;
            sh_n_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            op_q         <= op_d;
            width_q      <= width_d;
            data_q       <= data_d;
            noise_q      <= noise_d;
            cnt_q        <= cnt_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_errors_q <= res_errors_d;
            res_status_q <= res_status_d;
`ifdef ECC_SEQ_SKIP_UNCHANGED_EN
            sh_w_vld_q   <= sh_w_vld_d;
            sh_n_vld_q   <= sh_n_vld_d;
            sh_w_q       <= sh_w_d;
            sh_n_q       <= sh_n_d;
`endif
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_errors = res_errors_q;
    assign res_status = res_status_q;

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// tb_ecc_apb_sequencer: scenario tasks plus a result scoreboard for ecc_apb_sequencer.
// Runs with TIMEOUT_CYCLES=16; honours ECC_SEQ_SKIP_UNCHANGED_EN when defined.
module tb_ecc_apb_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [1:0]  cmd_width = '0;
    logic [31:0] cmd_data = '0;
    logic [31:0] cmd_noise = '0;
    logic [19:0] PADDR;
    logic [31:0] PWDATA;
    logic        PSEL, PENABLE, PWRITE;
    logic        operation_done = 1'b0;
    logic [31:0] data_out = '0;
    logic [1:0]  num_of_errors = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [1:0]  res_errors;
    logic [1:0]  res_status;
    logic        busy;

    ecc_apb_sequencer #(
        .DATA_WIDTH(32), .AMBA_ADDR_WIDTH(20), .AMBA_WORD(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_width(cmd_width), .cmd_data(cmd_data),
        .cmd_noise(cmd_noise), .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .operation_done(operation_done),
        .data_out(data_out), .num_of_errors(num_of_errors), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_errors(res_errors),
        .res_status(res_status), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  st;
        logic [1:0]  er;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    exp_t        got;
    int          checks = 0;
    int          passes = 0;
    logic        psel_seen = 1'b0;
    logic [19:0] setup_addr = '0;
    logic [31:0] setup_data = '0;

    always @(negedge clk) begin
        if (PSEL) psel_seen = 1'b1;
        if (PSEL && !PENABLE) begin
            setup_addr = PADDR;
            setup_data = PWDATA;
        end
        if (PSEL && PENABLE) begin
            checks++;
            if (PADDR === setup_addr && PWDATA === setup_data && PWRITE === 1'b1) passes++;
            else $display("FAIL apb_stable got %h/%h want %h/%h", PADDR, PWDATA, setup_addr, setup_data);
        end
        if (rst && res_valid && res_ready) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected result st=%b d=%h", res_status, res_data);
            end else begin
                got = sb.pop_front();
                if (res_status === got.st && res_errors === got.er && res_data === got.d) passes++;
                else $display("FAIL sb_result got st=%b er=%0d d=%h want st=%b er=%0d d=%h",
                              res_status, res_errors, res_data, got.st, got.er, got.d);
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [1:0] w,
                            input logic [31:0] d, input logic [31:0] n);
        int k;
        cmd_op = op;
        cmd_width = w;
        cmd_data = d;
        cmd_noise = n;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (cmd_ready) passes++;
        else $display("FAIL cmd_accept got ready=%b want 1", cmd_ready);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_for_wait();
        int k;
        k = 0;
        while (!(busy && !PSEL) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (busy && !PSEL) passes++;
        else $display("FAIL wait_entry got busy=%b psel=%b want 1/0", busy, PSEL);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, PSEL, PENABLE, PWRITE, res_valid, busy} === 6'b0 &&
            PADDR === 20'h0 && PWDATA === 32'h0 && res_status === 2'b00)
            passes++;
        else $display("FAIL reset_outputs got rdy=%b psel=%b rv=%b busy=%b want all 0",
                      cmd_ready, PSEL, res_valid, busy);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready === 1'b1 && busy === 1'b0) passes++;
        else $display("FAIL reset_release got rdy=%b busy=%b want 1/0", cmd_ready, busy);
    endtask

    task automatic test_encode();
        logic [19:0] ea[4];
        logic [31:0] ed[4];
        ea[0] = 20'h04; ea[1] = 20'h08; ea[2] = 20'h0C; ea[3] = 20'h00;
        ed[0] = 32'hA5; ed[1] = 32'h2;  ed[2] = 32'h0;  ed[3] = 32'h0;
        send_cmd(2'd0, 2'd2, 32'h0000_00A5, 32'h0);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (PSEL === 1'b1 && PWRITE === 1'b1 && PENABLE === k[0] &&
                PADDR === ea[k/2] && PWDATA === ed[k/2])
                passes++;
            else $display("FAIL enc_apb[%0d] got sel=%b en=%b a=%h d=%h want 1/%b %h %h",
                          k, PSEL, PENABLE, PADDR, PWDATA, k[0], ea[k/2], ed[k/2]);
            @(posedge clk); #1;
        end
        checks++;
        if (PSEL === 1'b0 && PENABLE === 1'b0 && busy === 1'b1) passes++;
        else $display("FAIL enc_wait_t9 got sel=%b busy=%b want 0/1", PSEL, busy);
        repeat (3) @(posedge clk);
        #1;
        operation_done = 1'b1;
        data_out = 32'hDEAD_BEEF;
        num_of_errors = 2'd0;
        sb.push_back('{st: 2'b00, er: 2'd0, d: 32'hDEAD_BEEF});
        @(posedge clk); #1;
        operation_done = 1'b0;
        data_out = 32'h0;
        checks++;
        if (res_valid === 1'b1) passes++;
        else $display("FAIL enc_res_valid got %b want 1", res_valid);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (res_valid === 1'b0 && cmd_ready === 1'b1 && busy === 1'b0) passes++;
        else $display("FAIL enc_return got rv=%b rdy=%b busy=%b want 0/1/0",
                      res_valid, cmd_ready, busy);
    endtask

    task automatic test_illegal();
        psel_seen = 1'b0;
        sb.push_back('{st: 2'b10, er: 2'd0, d: 32'h0});
        send_cmd(2'd3, 2'd1, 32'h1234_5678, 32'h1);
        checks++;
        if (res_valid === 1'b1 && res_status === 2'b10 && res_data === 32'h0) passes++;
        else $display("FAIL ill_t1 got rv=%b st=%b d=%h want 1/10/0",
                      res_valid, res_status, res_data);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        sb.push_back('{st: 2'b10, er: 2'd0, d: 32'h0});
        send_cmd(2'd1, 2'd3, 32'h5, 32'h0);
        checks++;
        if (res_valid === 1'b1 && res_status === 2'b10) passes++;
        else $display("FAIL ill_width got rv=%b st=%b want 1/10", res_valid, res_status);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (psel_seen === 1'b0) passes++;
        else $display("FAIL ill_no_apb got psel_seen=%b want 0", psel_seen);
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        logic [1:0]  e0, s0;
        send_cmd(2'd1, 2'd1, 32'h0000_1234, 32'h11);
        wait_for_wait();
        operation_done = 1'b1;
        data_out = 32'hCAFE_0001;
        num_of_errors = 2'd2;
        sb.push_back('{st: 2'b00, er: 2'd2, d: 32'hCAFE_0001});
        @(posedge clk); #1;
        operation_done = 1'b0;
        data_out = 32'h0;
        num_of_errors = 2'd0;
        d0 = res_data; e0 = res_errors; s0 = res_status;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (res_valid === 1'b1 && res_data === 32'hCAFE_0001 && res_data === d0 &&
                res_errors === e0 && res_status === s0 && cmd_ready === 1'b0 && busy === 1'b1)
                passes++;
            else $display("FAIL bp_hold[%0d] got rv=%b d=%h rdy=%b busy=%b want 1/cafe0001/0/1",
                          k, res_valid, res_data, cmd_ready, busy);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (res_valid === 1'b0 && cmd_ready === 1'b1 && busy === 1'b0) passes++;
        else $display("FAIL bp_release got rv=%b rdy=%b busy=%b want 0/1/0",
                      res_valid, cmd_ready, busy);
    endtask

    task automatic test_timeout();
        int n;
        logic seen;
        operation_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        operation_done = 1'b0;
        checks++;
        if (res_valid === 1'b0 && busy === 1'b0) passes++;
        else $display("FAIL idle_done_ignored got rv=%b busy=%b want 0/0", res_valid, busy);
        sb.push_back('{st: 2'b01, er: 2'd0, d: 32'h0});
        send_cmd(2'd2, 2'd0, 32'h0000_00FF, 32'h22);
        wait_for_wait();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            seen = res_valid;
        end
        checks++;
        if (seen && n == 17 && res_status === 2'b01 && res_data === 32'h0) passes++;
        else $display("FAIL timeout_latency got n=%0d st=%b want 17/01", n, res_status);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic bad;
        send_cmd(2'd0, 2'd2, 32'h0000_0077, 32'h33);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (PSEL === 1'b1 && PENABLE === 1'b1 && PADDR === 20'h0C) passes++;
        else $display("FAIL rstmid_noise got sel=%b en=%b a=%h want 1/1/0c", PSEL, PENABLE, PADDR);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (PSEL === 1'b0 && PENABLE === 1'b0 && PWRITE === 1'b0 && busy === 1'b0) passes++;
        else $display("FAIL rstmid_drop got sel=%b en=%b wr=%b busy=%b want 0", PSEL, PENABLE,
                      PWRITE, busy);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_ready === 1'b1) passes++;
        else $display("FAIL rstmid_ready got %b want 1", cmd_ready);
        bad = 1'b0;
        repeat (6) begin
            if (res_valid !== 1'b0 || PSEL !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (!bad) passes++;
        else $display("FAIL rstmid_no_result got activity=%b want 0", bad);
    endtask

    task automatic test_back_to_back();
        logic [19:0] ea[4];
        logic [31:0] ed[4];
        int nw;
        for (int j = 0; j < 2; j++) begin
            ea[0] = 20'h04; ea[1] = 20'h08; ea[2] = 20'h0C; ea[3] = 20'h00;
            ed[0] = 32'h100 + j; ed[1] = 32'h1; ed[2] = 32'h55; ed[3] = 32'h2;
            nw = 4;
`ifdef ECC_SEQ_SKIP_UNCHANGED_EN
            if (j == 1) begin
                ea[1] = 20'h00; ed[1] = 32'h2;
                nw = 2;
            end
`endif
            send_cmd(2'd2, 2'd1, 32'h100 + j, 32'h55);
            for (int k = 0; k < 2 * nw; k++) begin
                checks++;
                if (PSEL === 1'b1 && PENABLE === k[0] && PADDR === ea[k/2] && PWDATA === ed[k/2])
                    passes++;
                else $display("FAIL b2b_apb[%0d][%0d] got sel=%b en=%b a=%h d=%h want %h %h",
                              j, k, PSEL, PENABLE, PADDR, PWDATA, ea[k/2], ed[k/2]);
                @(posedge clk); #1;
            end
            checks++;
            if (PSEL === 1'b0 && busy === 1'b1) passes++;
            else $display("FAIL b2b_wait[%0d] got sel=%b busy=%b want 0/1", j, PSEL, busy);
            operation_done = 1'b1;
            data_out = 32'hA000 + j;
            num_of_errors = 2'd1;
            sb.push_back('{st: 2'b00, er: 2'd1, d: 32'hA000 + j});
            @(posedge clk); #1;
            operation_done = 1'b0;
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_illegal();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL sb_leftover got %0d want 0", sb.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got hang want finish");
        $fatal(1);
    end

endmodule
